// File: rtl/dvp_pattern_gen.sv
// -----------------------------------------------------------------------------
// dvp_pattern_gen
// Synthesizable DVP camera-source model. Produces vsync/href/pixel-byte timing
// of an image sensor with programmable active size and blanking, a luma ramp
// pattern (Y = x + y + frame_cnt), UYVY/YUYV/RAW8 byte ordering, frame-aligned
// start/stop and a completed-frame counter. Lives in the pixel-clock domain.
//
// Ports
//   pclk       in   pixel clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   en         in   run request, sampled only at frame boundaries
//   mode       in   0 = UYVY, 1 = YUYV, 2 = RAW8, 3 = UYVY
//   vsync      out  high for the whole of line 0
//   href       out  high on active bytes
//   dout       out  pixel byte, 0 outside the active window
//   sof        out  pulse on the first cycle of a frame
//   eof        out  pulse on the last cycle of a frame
//   frame_cnt  out  number of completed frames (wraps)
//
// State   | meaning
// --------+--------------------------------------------------------------
// IDLE    | counters parked at 0, outputs 0, waiting for en
// RUN     | generating a frame, en still asserted
// DRAIN   | generating a frame after en dropped; runs to the frame end
// -----------------------------------------------------------------------------
module dvp_pattern_gen #(
    parameter int WDT       = 64,
    parameter int HGT       = 48,
    parameter int D         = 8,
    parameter int BLK_WDT_B = 8,
    parameter int BLK_WDT_E = 4,
    parameter int BLK_HGT_B = 2,
    parameter int BLK_HGT_E = 1,
    parameter int FC_W      = 16
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic            en,
    input  logic [1:0]      mode,
    output logic            vsync,
    output logic            href,
    output logic [D-1:0]    dout,
    output logic            sof,
    output logic            eof,
    output logic [FC_W-1:0] frame_cnt
);

    localparam int TOT_WDT = WDT + BLK_WDT_B + BLK_WDT_E;
    localparam int TOT_HGT = HGT + BLK_HGT_B + BLK_HGT_E;
    localparam int HW      = $clog2(TOT_WDT + 1);
    localparam int VW      = $clog2(TOT_HGT + 1);

    localparam logic [HW-1:0] H_LAST  = HW'(TOT_WDT - 1);
    localparam logic [HW-1:0] H_ACT_B = HW'(BLK_WDT_B);
    localparam logic [HW-1:0] H_ACT_E = HW'(BLK_WDT_B + WDT);
    localparam logic [VW-1:0] V_LAST  = VW'(TOT_HGT - 1);
    localparam logic [VW-1:0] V_ACT_B = VW'(BLK_HGT_B);
    localparam logic [VW-1:0] V_ACT_E = VW'(BLK_HGT_B + HGT);

    // x + y = hcnt + vcnt - (BLK_WDT_B + BLK_HGT_B), taken modulo 2^D
    localparam logic [D-1:0]  PIX_OFS = D'(BLK_WDT_B + BLK_HGT_B);
    localparam logic [D-1:0]  C_BYTE  = {1'b1, {(D-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [1:0] M_YUYV  = 2'd1;
    localparam logic [1:0] M_RAW8  = 2'd2;

    logic [1:0]      r_state;
    logic [HW-1:0]   r_hcnt;
    logic [VW-1:0]   r_vcnt;
    logic            r_phase;
    logic [1:0]      r_mode;
    logic [FC_W-1:0] r_frame_cnt;
    logic            r_vsync;
    logic            r_href;
    logic [D-1:0]    r_dout;
    logic            r_sof;
    logic            r_eof;

    logic [1:0]      w_nxt_state;
    logic [HW-1:0]   w_nxt_h;
    logic [VW-1:0]   w_nxt_v;
    logic            w_nxt_p;
    logic [1:0]      w_nxt_mode;
    logic [FC_W-1:0] w_nxt_fc;
    logic            w_nxt_act;

    logic            w_last_phase;
    logic            w_last;
    logic            w_nxt_last_phase;
    logic            w_nxt_valid;
    logic            w_nxt_last;
    logic            w_nxt_first;
    logic [D-1:0]    w_luma;
    logic [D-1:0]    w_byte;

    // RAW8 has a single phase per pixel, so every cycle ends a pixel
    assign w_last_phase = (r_mode == M_RAW8) | r_phase;
    assign w_last       = (r_vcnt == V_LAST) && (r_hcnt == H_LAST) && w_last_phase;

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_h     = r_hcnt;
        w_nxt_v     = r_vcnt;
        w_nxt_p     = r_phase;
        w_nxt_mode  = r_mode;
        w_nxt_fc    = r_frame_cnt;
        w_nxt_act   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_nxt_h = '0;
                w_nxt_v = '0;
                w_nxt_p = 1'b0;
                if (en) begin
                    w_nxt_state = S_RUN;
                    w_nxt_mode  = mode;
                    w_nxt_act   = 1'b1;
                end
            end
            default: begin
                w_nxt_act = 1'b1;
                if (w_last) begin
                    w_nxt_h  = '0;
                    w_nxt_v  = '0;
                    w_nxt_p  = 1'b0;
                    w_nxt_fc = r_frame_cnt + FC_W'(1);
                    if (en) begin
                        w_nxt_state = S_RUN;
                        w_nxt_mode  = mode;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_act   = 1'b0;
                    end
                end else begin
                    if (!en) begin
                        w_nxt_state = S_DRAIN;
                    end
                    if (w_last_phase) begin
                        w_nxt_p = 1'b0;
                        if (r_hcnt == H_LAST) begin
                            w_nxt_h = '0;
                            w_nxt_v = r_vcnt + VW'(1);
                        end else begin
                            w_nxt_h = r_hcnt + HW'(1);
                        end
                    end else begin
                        w_nxt_p = 1'b1;
                    end
                end
            end
        endcase
    end

    // Outputs are computed from the next counter state and registered, so
    // the registered outputs always describe the counters of the same cycle.
    assign w_nxt_last_phase = (w_nxt_mode == M_RAW8) | w_nxt_p;
    assign w_nxt_valid      = (w_nxt_v >= V_ACT_B) && (w_nxt_v < V_ACT_E) &&
                              (w_nxt_h >= H_ACT_B) && (w_nxt_h < H_ACT_E);
    assign w_nxt_last       = (w_nxt_v == V_LAST) && (w_nxt_h == H_LAST) && w_nxt_last_phase;
    assign w_nxt_first      = (w_nxt_v == '0) && (w_nxt_h == '0) && !w_nxt_p;
    assign w_luma           = D'(w_nxt_h) + D'(w_nxt_v) + D'(w_nxt_fc) - PIX_OFS;

    always_comb begin
        w_byte = w_luma;
        if (w_nxt_mode == M_YUYV) begin
            w_byte = w_nxt_p ? C_BYTE : w_luma;
        end else if (w_nxt_mode != M_RAW8) begin
            w_byte = w_nxt_p ? w_luma : C_BYTE;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_hcnt      <= '0;
            r_vcnt      <= '0;
            r_phase     <= 1'b0;
            r_mode      <= '0;
            r_frame_cnt <= '0;
            r_vsync     <= 1'b0;
            r_href      <= 1'b0;
            r_dout      <= '0;
            r_sof       <= 1'b0;
            r_eof       <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_hcnt      <= w_nxt_h;
            r_vcnt      <= w_nxt_v;
            r_phase     <= w_nxt_p;
            r_mode      <= w_nxt_mode;
            r_frame_cnt <= w_nxt_fc;
            r_vsync     <= w_nxt_act && (w_nxt_v == '0);
            r_href      <= w_nxt_act && w_nxt_valid;
            r_dout      <= (w_nxt_act && w_nxt_valid) ? w_byte : '0;
            r_sof       <= w_nxt_act && w_nxt_first;
            r_eof       <= w_nxt_act && w_nxt_last;
        end
    end

    assign vsync     = r_vsync;
    assign href      = r_href;
    assign dout      = r_dout;
    assign sof       = r_sof;
    assign eof       = r_eof;
    assign frame_cnt = r_frame_cnt;

endmodule

// File: tb/tb_dvp_pattern_gen.sv
module tb_dvp_pattern_gen;

    localparam int WDT  = 4;
    localparam int HGT  = 2;
    localparam int D    = 8;
    localparam int BWB  = 2;
    localparam int BWE  = 1;
    localparam int BHB  = 2;
    // trailing vertical blanking at zero: a UYVY frame is 7 x 4 x 2 = 56 cycles
    localparam int BHE  = 0;
    localparam int FC_W = 2;
    localparam int TOT_W = WDT + BWB + BWE;
    localparam int TOT_H = HGT + BHB + BHE;

    typedef struct packed {
        logic            vs;
        logic            hr;
        logic [D-1:0]    d;
        logic            so;
        logic            eo;
        logic [FC_W-1:0] fc;
    } exp_t;

    logic            pclk = 1'b0;
    logic            rst_n;
    logic            en;
    logic [1:0]      mode;
    logic            vsync;
    logic            href;
    logic [D-1:0]    dout;
    logic            sof;
    logic            eof;
    logic [FC_W-1:0] frame_cnt;

    int errors = 0;
    int checks = 0;

    exp_t exp_q[$];
    exp_t fbuf[$];
    logic [FC_W-1:0] fc_m = '0;

    dvp_pattern_gen #(
        .WDT(WDT), .HGT(HGT), .D(D), .BLK_WDT_B(BWB), .BLK_WDT_E(BWE),
        .BLK_HGT_B(BHB), .BLK_HGT_E(BHE), .FC_W(FC_W)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .en(en), .mode(mode),
        .vsync(vsync), .href(href), .dout(dout), .sof(sof), .eof(eof),
        .frame_cnt(frame_cnt)
    );

    always #5 pclk = ~pclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: a whole frame is laid out line by line, pixel by pixel
    function automatic void gen_frame(input logic [1:0] m, input logic [FC_W-1:0] fc);
        int bpc;
        int total;
        int n;
        bpc   = (m == 2'd2) ? 1 : 2;
        total = TOT_W * TOT_H * bpc;
        n     = 0;
        for (int v = 0; v < TOT_H; v++) begin
            for (int h = 0; h < TOT_W; h++) begin
                for (int p = 0; p < bpc; p++) begin
                    exp_t e;
                    bit   act;
                    logic [D-1:0] y;
                    logic [D-1:0] c;
                    logic [D-1:0] b;
                    act = (v >= BHB) && (v < BHB + HGT) && (h >= BWB) && (h < BWB + WDT);
                    y   = D'(((h - BWB) + (v - BHB) + int'(fc)) % 256);
                    c   = D'(1 << (D - 1));
                    if (m == 2'd2)      b = y;
                    else if (m == 2'd1) b = (p == 0) ? y : c;
                    else                b = (p == 0) ? c : y;
                    e.vs = (v == 0);
                    e.hr = act;
                    e.d  = act ? b : '0;
                    e.so = (n == 0);
                    e.eo = (n == total - 1);
                    e.fc = fc;
                    fbuf.push_back(e);
                    n++;
                end
            end
        end
    endfunction

    // Stimulus side: at each edge predict the outputs of the cycle that starts
    always @(posedge pclk) begin
        exp_t e;
        if (!rst_n) begin
            fbuf.delete();
            fc_m = '0;
            e    = '0;
            exp_q.push_back(e);
        end else begin
            if (fbuf.size() == 0 && en) begin
                gen_frame(mode, fc_m);
                fc_m = fc_m + FC_W'(1);
            end
            if (fbuf.size() > 0) begin
                e = fbuf.pop_front();
            end else begin
                e    = '0;
                e.fc = fc_m;
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: compare every presented output cycle against the scoreboard
    int   cyc = 0;
    bit   in_first = 0;
    bit   first_done = 0;
    int   f_cyc = 0;
    int   vs_cnt = 0;
    logic prev_href = 1'b0;
    int   hr_starts[$];
    logic [D-1:0] fbytes[$];

    always @(negedge pclk) begin
        exp_t e;
        exp_t g;
        logic [D-1:0] ref_bytes [8];
        ref_bytes = '{8'h80, 8'h00, 8'h80, 8'h01, 8'h80, 8'h02, 8'h80, 8'h03};
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g.vs = vsync; g.hr = href; g.d = dout; g.so = sof; g.eo = eof; g.fc = frame_cnt;
            checks++;
            if (g !== e) begin
                errors++;
                $display("FAIL stream cycle %0d: got vs=%b hr=%b d=%h sof=%b eof=%b fc=%0d, exp vs=%b hr=%b d=%h sof=%b eof=%b fc=%0d",
                         cyc, g.vs, g.hr, g.d, g.so, g.eo, g.fc, e.vs, e.hr, e.d, e.so, e.eo, e.fc);
            end
        end
        if (sof && !first_done && !in_first) begin
            in_first = 1;
            f_cyc    = 0;
        end
        if (in_first) begin
            if (vsync) vs_cnt++;
            if (href && !prev_href) hr_starts.push_back(f_cyc);
            if (href && fbytes.size() < 8) fbytes.push_back(dout);
            if (eof) begin
                checks++;
                if (f_cyc != 55) begin
                    errors++;
                    $display("FAIL first_eof_pos: got %0d exp 55", f_cyc);
                end
                checks++;
                if (vs_cnt != 14) begin
                    errors++;
                    $display("FAIL first_vsync_len: got %0d exp 14", vs_cnt);
                end
                checks++;
                if (hr_starts.size() != 2 || hr_starts[0] != 32 || hr_starts[1] != 46) begin
                    errors++;
                    $display("FAIL first_href_starts: got %0d bursts (first %0d) exp 2 bursts at 32,46",
                             hr_starts.size(), (hr_starts.size() > 0) ? hr_starts[0] : -1);
                end
                for (int i = 0; i < 8; i++) begin
                    checks++;
                    if (i >= fbytes.size() || fbytes[i] !== ref_bytes[i]) begin
                        errors++;
                        $display("FAIL first_line_byte[%0d]: got %h exp %h", i,
                                 (i < fbytes.size()) ? fbytes[i] : 8'hxx, ref_bytes[i]);
                    end
                end
                in_first   = 0;
                first_done = 1;
            end
            f_cyc++;
        end
        prev_href = href;
        cyc++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge pclk);
        #1;
    endtask

    task automatic wait_sof(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            @(negedge pclk);
            n++;
        end while (!sof && n < budget);
        checks++;
        if (!sof) begin
            errors++;
            $display("FAIL %s: no sof within %0d cycles", tag, budget);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 2'd0;
        step(3);
        rst_n = 1'b1;
        step(3);

        // UYVY frame, mode switch mid-frame only affects the next frame
        en = 1'b1; mode = 2'd0;
        wait_sof(10, "sof_f0");
        step(20); mode = 2'd1;
        wait_sof(80, "sof_f1_yuyv");
        step(10); mode = 2'd2;
        wait_sof(80, "sof_f2_raw8");
        step(5);  mode = 2'd0;
        wait_sof(40, "sof_f3_uyvy");
        // en dropped mid-frame: the frame drains, then idle
        step(20); en = 1'b0;
        step(90);

        // restart in the reserved mode, then reset in the middle of an href burst
        en = 1'b1; mode = 2'd3;
        wait_sof(10, "sof_restart");
        wait_sof(80, "sof_before_reset");
        step(35);
        rst_n = 1'b0;
        #1;
        checks++;
        if (href !== 1'b0) begin errors++; $display("FAIL async_rst_href: got %b exp 0", href); end
        checks++;
        if (dout !== '0) begin errors++; $display("FAIL async_rst_dout: got %h exp 00", dout); end
        checks++;
        if (frame_cnt !== '0) begin errors++; $display("FAIL async_rst_fc: got %0d exp 0", frame_cnt); end
        checks++;
        if ({vsync, sof, eof} !== 3'b000) begin
            errors++;
            $display("FAIL async_rst_ctl: got vs/sof/eof=%b exp 000", {vsync, sof, eof});
        end
        step(2);
        rst_n = 1'b1;
        wait_sof(10, "sof_after_reset");
        step(60);

        // randomized en/mode traffic
        for (int i = 0; i < 30; i++) begin
            step($urandom_range(1, 90));
            en   = ($urandom_range(0, 3) != 0);
            mode = 2'($urandom_range(0, 3));
        end

        en = 1'b0;
        step(130);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left exp 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
